// File: rtl/vdp_host_port_if.sv
// Host-side register bus and name-RAM write stream of the VDP host port.
// The slave modport is the port block; the master side is the CPU plus
// the name-RAM write port.
interface vdp_host_port_if;
    logic        cpu_cs;
    logic        cpu_we;
    logic [1:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    modport slave (
        input  cpu_cs,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_rdata,
        output wr_valid,
        input  wr_ready,
        output wr_addr,
        output wr_data
    );

    modport master (
        output cpu_cs,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_rdata,
        input  wr_valid,
        output wr_ready,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/vdp_host_port.sv
// VDP host port: CPU-visible pointer/attribute registers feeding a small
// write queue that drains into the name RAM with a valid/ready handshake.
module vdp_host_port #(
    parameter int unsigned DEPTH = 4
) (
    input  logic            dot_clk,
    input  logic            reset,
    vdp_host_port_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [11:0]   ptr;
    logic          inc_mode;
    logic [7:0]    attr_latch;
    logic          ovf;

    logic [11:0]   addr_mem [DEPTH];
    logic [15:0]   data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [LW-1:0] level;

    logic          empty;
    logic          full;
    logic          wr_access;
    logic          rd_access;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic [11:0]   ptr_step;

    // Access decode and queue status; cpu_cs is masked while reset is high.
    always_comb begin
        empty     = (level == '0);
        full      = (level == FULL_LVL);
        wr_access = bus.cpu_cs & bus.cpu_we & ~reset;
        rd_access = bus.cpu_cs & ~bus.cpu_we & ~reset;
        push_req  = wr_access & (bus.cpu_addr == 2'd3);
        // Fullness is judged before any same-cycle pop frees a slot.
        push_ok   = push_req & ~full;
        pop       = ~empty & bus.wr_ready;
        ptr_step  = inc_mode ? 12'd64 : 12'd1;
    end

    // Pointer, increment mode and attribute latch registers.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            ptr        <= '0;
            inc_mode   <= 1'b0;
            attr_latch <= '0;
        end else if (wr_access) begin
            case (bus.cpu_addr)
                2'd0: ptr[7:0] <= bus.cpu_wdata;
                2'd1: begin
                    ptr[11:8] <= bus.cpu_wdata[3:0];
                    inc_mode  <= bus.cpu_wdata[7];
                end
                2'd2: attr_latch <= bus.cpu_wdata;
                default: begin
                    if (!full) ptr <= ptr + ptr_step;
                end
            endcase
        end
    end

    // Queue head/tail pointers and fill level.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop)     head <= head + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Queue storage; entries capture address and data at push time.
    always_ff @(posedge dot_clk) begin
        if (push_ok) begin
            addr_mem[tail] <= ptr;
            data_mem[tail] <= {bus.cpu_wdata, attr_latch};
        end
    end

    // Sticky overflow flag; a same-cycle overflow beats the read-clear.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (push_req && full) begin
            ovf <= 1'b1;
        end else if (rd_access && bus.cpu_addr == 2'd0) begin
            ovf <= 1'b0;
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            bus.cpu_rdata <= '0;
        end else if (rd_access) begin
            case (bus.cpu_addr)
                2'd0:    bus.cpu_rdata <= {5'b0, ovf, full, empty};
                2'd1:    bus.cpu_rdata <= 8'(level);
                2'd2:    bus.cpu_rdata <= ptr[7:0];
                default: bus.cpu_rdata <= {inc_mode, 3'b0, ptr[11:8]};
            endcase
        end
    end

    // Head of queue drives the name-RAM write port.
    always_comb begin
        bus.wr_valid = ~empty;
        bus.wr_addr  = addr_mem[head];
        bus.wr_data  = data_mem[head];
    end
endmodule

// File: tb/tb_vdp_host_port.sv
// Bench for vdp_host_port: table-driven register accesses plus hand-written
// overflow, backpressure and reset sequences; queue writes go through a
// scoreboard of expected {addr, data} popped on each handshake.
module tb_vdp_host_port;
    logic dot_clk;
    logic reset;
    int   checks;
    int   errors;

    logic [27:0] sb [$];

    vdp_host_port_if bus ();

    vdp_host_port #(.DEPTH(4)) dut (
        .dot_clk (dot_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial dot_clk = 1'b0;
    always #5 dot_clk = ~dot_clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic        chk;
        logic [7:0]  exp;
        logic        push;
        logic [11:0] ea;
        logic [15:0] ed;
    } vec_t;

    vec_t vecs [13];

    // Handshake monitor: every accepted head must match the scoreboard front.
    always @(negedge dot_clk) begin
        logic [27:0] e;
        if (!reset && bus.wr_valid && bus.wr_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got addr=%03h data=%04h want none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = sb.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== e) begin
                    errors++;
                    $display("FAIL sb_entry got addr=%03h data=%04h want addr=%03h data=%04h",
                             bus.wr_addr, bus.wr_data, e[27:16], e[15:0]);
                end
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %02h want %02h", name, got, want);
        end
    endtask

    // One bus cycle: drive at posedge+1, returns at next posedge+1.
    task automatic cyc(input logic cs, input logic we, input logic [1:0] a,
                       input logic [7:0] d);
        bus.cpu_cs    = cs;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(posedge dot_clk);
        #1;
        bus.cpu_cs = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] want);
        cyc(1'b1, 1'b0, a, 8'h00);
        check8(name, bus.cpu_rdata, want);
    endtask

    task automatic push_exp(input logic [11:0] a, input logic [15:0] d);
        sb.push_back({a, d});
    endtask

    task automatic drain(input string name);
        int n;
        bus.wr_ready = 1'b1;
        n = 0;
        while (bus.wr_valid && n < 20) begin
            @(posedge dot_clk);
            #1;
            n++;
        end
        checks++;
        if (bus.wr_valid || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got valid=%0d pending=%0d want valid=0 pending=0",
                     name, bus.wr_valid, sb.size());
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.cpu_cs    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 2'd0;
        bus.cpu_wdata = 8'h00;
        bus.wr_ready  = 1'b1;

        //           we    addr  wdata  chk   exp    push  ea       ed
        vecs[0]  = '{1'b1, 2'd0, 8'h3F, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000};
        vecs[1]  = '{1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000};
        vecs[2]  = '{1'b1, 2'd2, 8'hA5, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000};
        vecs[3]  = '{1'b1, 2'd3, 8'h41, 1'b0, 8'h00, 1'b1, 12'h03F, 16'h41A5};
        vecs[4]  = '{1'b0, 2'd2, 8'h00, 1'b1, 8'h40, 1'b0, 12'h000, 16'h0000};
        vecs[5]  = '{1'b1, 2'd0, 8'hC5, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000};
        vecs[6]  = '{1'b1, 2'd1, 8'h8F, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000};
        vecs[7]  = '{1'b1, 2'd3, 8'h11, 1'b0, 8'h00, 1'b1, 12'hFC5, 16'h11A5};
        vecs[8]  = '{1'b1, 2'd3, 8'h22, 1'b0, 8'h00, 1'b1, 12'h005, 16'h22A5};
        vecs[9]  = '{1'b0, 2'd2, 8'h00, 1'b1, 8'h45, 1'b0, 12'h000, 16'h0000};
        vecs[10] = '{1'b0, 2'd3, 8'h00, 1'b1, 8'h80, 1'b0, 12'h000, 16'h0000};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h01, 1'b0, 12'h000, 16'h0000};
        vecs[12] = '{1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, 12'h000, 16'h0000};

        repeat (2) @(posedge dot_clk);
        #1;
        reset = 1'b0;

        // Reset state
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0d want 0", bus.wr_valid);
        end
        check8("reset_rdata", bus.cpu_rdata, 8'h00);
        rd_check("reset_reg0", 2'd0, 8'h01);
        rd_check("reset_reg2", 2'd2, 8'h00);
        rd_check("reset_reg3", 2'd3, 8'h00);

        // Basic write and row-increment wrap, wr_ready held high
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].push) push_exp(vecs[i].ea, vecs[i].ed);
            cyc(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) check8($sformatf("vec%0d_reg%0d", i, vecs[i].addr),
                                    bus.cpu_rdata, vecs[i].exp);
        end
        drain("table");

        // Overflow: five pushes into a stalled 4-deep queue
        bus.wr_ready = 1'b0;
        wr(2'd1, 8'h00);
        wr(2'd0, 8'h00);
        wr(2'd2, 8'h77);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_exp(12'(i), {8'(8'h10 + i), 8'h77});
            wr(2'd3, 8'(8'h10 + i));
        end
        rd_check("ovf_reg0", 2'd0, 8'h06);
        rd_check("ovf_ptr", 2'd2, 8'h04);
        rd_check("ovf_reg0_again", 2'd0, 8'h02);
        rd_check("ovf_level", 2'd1, 8'h04);

        // Push while full with a same-cycle pop: head leaves, push dropped
        bus.wr_ready = 1'b1;
        wr(2'd3, 8'hEE);
        bus.wr_ready = 1'b0;
        rd_check("fullpop_level", 2'd1, 8'h03);
        rd_check("fullpop_reg0", 2'd0, 8'h04);
        rd_check("fullpop_ptr", 2'd2, 8'h04);
        drain("ovf");

        // Backpressure: 3 entries, ready 1,0,1,1 then level settles at 0
        bus.wr_ready = 1'b0;
        wr(2'd0, 8'h80);
        wr(2'd2, 8'h3C);
        push_exp(12'h080, 16'hA13C);
        wr(2'd3, 8'hA1);
        push_exp(12'h081, 16'hA23C);
        wr(2'd3, 8'hA2);
        push_exp(12'h082, 16'hA33C);
        wr(2'd3, 8'hA3);
        bus.wr_ready = 1'b1;
        rd_check("bp_level0", 2'd1, 8'h03);
        bus.wr_ready = 1'b0;
        @(negedge dot_clk);
        checks++;
        if (bus.wr_addr !== 12'h081 || bus.wr_data !== 16'hA23C) begin
            errors++;
            $display("FAIL bp_stall_head got %03h/%04h want 081/A23C",
                     bus.wr_addr, bus.wr_data);
        end
        @(posedge dot_clk);
        #1;
        check8("bp_level1", 8'(dut.level), 8'h02);
        checks++;
        if (bus.wr_addr !== 12'h081 || bus.wr_data !== 16'hA23C || !bus.wr_valid) begin
            errors++;
            $display("FAIL bp_stall_hold got %03h/%04h v=%0d want 081/A23C v=1",
                     bus.wr_addr, bus.wr_data, bus.wr_valid);
        end
        bus.wr_ready = 1'b1;
        rd_check("bp_level2", 2'd1, 8'h02);
        rd_check("bp_level3", 2'd1, 8'h01);
        bus.wr_ready = 1'b0;
        rd_check("bp_level4", 2'd1, 8'h00);
        drain("bp");

        // Reset mid-burst with cpu_cs active during reset
        bus.wr_ready = 1'b0;
        wr(2'd3, 8'h51);
        wr(2'd3, 8'h52);
        reset         = 1'b1;
        bus.cpu_cs    = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 2'd0;
        bus.cpu_wdata = 8'h55;
        @(posedge dot_clk);
        #1;
        reset      = 1'b0;
        bus.cpu_cs = 1'b0;
        checks++;
        if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %0d want 0", bus.wr_valid);
        end
        rd_check("rst_reg0", 2'd0, 8'h01);
        rd_check("rst_reg2", 2'd2, 8'h00);
        drain("rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
